// File: rtl/readout_pkg.sv
// Shared definitions for the readout classifier scheduler.
//   sched_state_t : scheduler FSM states
//   I_/Q_ offsets : bit positions of the I/Q fields inside an AXIS word
//   CH_BITS       : width of a channel index
//   REGION_BITS   : width of the per-channel BRAM address pointer
package readout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    STORE = 2'd3
  } sched_state_t;

  localparam int unsigned I_MSB = 31;
  localparam int unsigned I_LSB = 18;
  localparam int unsigned Q_MSB = 17;
  localparam int unsigned Q_LSB = 4;

  function automatic int unsigned CH_BITS(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned REGION_BITS(input int unsigned addr_bits,
                                              input int unsigned n);
    return addr_bits - CH_BITS(n);
  endfunction

endpackage

// File: rtl/readout_classify_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req       : request vector
//   i_rr_ptr    : index with top priority
//   o_grant     : one-hot grant (all zero when no request)
//   o_grant_idx : index of the granted request (0 when no request)
module rr_arbiter
  import readout_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = CH_BITS(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_rr_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx
);

  logic [IW-1:0] w_idx;
  logic          w_found;

  // Scan upward from i_rr_ptr with wrap; the first set request wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = IW'((32'(i_rr_ptr) + i) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/readout_classify_scheduler.sv
// Shares one NN readout classifier between NUM_CH readout channels.
//   ap_clk, rst     : clock, synchronous active-high reset
//   cfg_enable      : per-channel enable mask
//   cfg_clear       : pulse, clears address pointers, drop counters, err_timeout
//   trigger         : per-channel trigger pulses
//   in_TDATA/TVALID : per-channel AXIS sample streams (no back-pressure)
//   cls_*           : muxed stream to the classifier, start pulse, done/pred back
//   out_ADDR/DATA/WE: prediction BRAM write port, address {grant_ch, ptr}
//   busy, grant_ch  : scheduler status
//   drop_cnt        : per-channel saturating dropped-trigger counters
//   err_timeout     : sticky classifier timeout flag
module readout_classify_scheduler
  import readout_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WINDOW_SIZE    = 400,
  parameter int unsigned PRED_BITS      = 2,
  parameter int unsigned BRAM_ADDR_BITS = 14,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned DROP_BITS      = 8
) (
  input  logic                           ap_clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              cfg_enable,
  input  logic                           cfg_clear,
  input  logic [NUM_CH-1:0]              trigger,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   in_TDATA,
  input  logic [NUM_CH-1:0]              in_TVALID,
  output logic                           cls_start,
  output logic [DATA_WIDTH-1:0]          cls_TDATA,
  output logic                           cls_TVALID,
  output logic                           cls_TLAST,
  input  logic                           cls_done,
  input  logic [PRED_BITS-1:0]           cls_pred,
  output logic [BRAM_ADDR_BITS-1:0]      out_ADDR,
  output logic [PRED_BITS-1:0]           out_DATA,
  output logic                           out_WE,
  output logic                           busy,
  output logic [$clog2(NUM_CH)-1:0]      grant_ch,
  output logic [NUM_CH*DROP_BITS-1:0]    drop_cnt,
  output logic                           err_timeout
);

  localparam int unsigned CW = CH_BITS(NUM_CH);
  localparam int unsigned RW = REGION_BITS(BRAM_ADDR_BITS, NUM_CH);
  localparam int unsigned BW = $clog2(WINDOW_SIZE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t           r_state;
  logic [CW-1:0]          r_grant;
  logic [CW-1:0]          r_rr;
  logic [RW-1:0]          r_ptr  [NUM_CH];
  logic [DROP_BITS-1:0]   r_drop [NUM_CH];
  logic [BW-1:0]          r_beat;
  logic [TW-1:0]          r_wait;
  logic                   r_start;
  logic [DATA_WIDTH-1:0]  r_tdata;
  logic                   r_tvalid;
  logic                   r_tlast;
  logic                   r_we;
  logic [PRED_BITS-1:0]   r_data;
  logic                   r_err;

  logic [NUM_CH-1:0]      w_req;
  logic [NUM_CH-1:0]      w_grant_oh;
  logic [CW-1:0]          w_grant_idx;
  logic [NUM_CH-1:0]      w_drop_inc;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic                   w_sel_valid;

  assign w_req = trigger & cfg_enable;

  rr_arbiter #(
    .N  (NUM_CH),
    .IW (CW)
  ) u_arb (
    .i_req       (w_req),
    .i_rr_ptr    (r_rr),
    .o_grant     (w_grant_oh),
    .o_grant_idx (w_grant_idx)
  );

  // In IDLE only the losers of arbitration are dropped; otherwise every
  // enabled trigger is dropped because the classifier is occupied.
  assign w_drop_inc = (r_state == IDLE) ? (w_req & ~w_grant_oh) : w_req;

  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (r_grant == CW'(c)) begin
        w_sel_data  = in_TDATA[c*DATA_WIDTH +: DATA_WIDTH];
        w_sel_valid = in_TVALID[c];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr     <= '0;
      r_beat   <= '0;
      r_wait   <= '0;
      r_start  <= 1'b0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_we     <= 1'b0;
      r_data   <= '0;
      r_err    <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_ptr[c]  <= '0;
        r_drop[c] <= '0;
      end
    end else begin
      r_start <= 1'b0;
      r_we    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_grant <= w_grant_idx;
            r_rr    <= (w_grant_idx == CW'(NUM_CH - 1)) ? '0 : w_grant_idx + 1'b1;
            r_start <= 1'b1;
            r_beat  <= '0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          // The last beat is presented for one cycle while still in LOAD,
          // so TVALID/TLAST never appear outside LOAD.
          if (r_tlast) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_wait   <= '0;
            r_state  <= WAIT;
          end else begin
            r_tdata  <= w_sel_data;
            r_tvalid <= w_sel_valid;
            if (w_sel_valid) begin
              r_beat  <= r_beat + 1'b1;
              r_tlast <= (r_beat == BW'(WINDOW_SIZE - 1));
            end
          end
        end
        WAIT: begin
          if (cls_done) begin
            r_data  <= cls_pred;
            r_we    <= 1'b1;
            r_state <= STORE;
          end else if (r_wait == TW'(TIMEOUT_CYCLES - 1)) begin
            r_data  <= '1;
            r_err   <= 1'b1;
            r_we    <= 1'b1;
            r_state <= STORE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        STORE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // cfg_clear overrides the STORE increment; the write itself already
      // used the pre-clear pointer through out_ADDR.
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (cfg_clear) begin
          r_ptr[c]  <= '0;
          r_drop[c] <= '0;
        end else begin
          if (r_state == STORE && r_grant == CW'(c))
            r_ptr[c] <= r_ptr[c] + 1'b1;
          if (w_drop_inc[c] && r_drop[c] != '1)
            r_drop[c] <= r_drop[c] + 1'b1;
        end
      end
      if (cfg_clear)
        r_err <= 1'b0;
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      drop_cnt[c*DROP_BITS +: DROP_BITS] = r_drop[c];
  end

  assign cls_start   = r_start;
  assign cls_TDATA   = r_tdata;
  assign cls_TVALID  = r_tvalid;
  assign cls_TLAST   = r_tlast;
  assign out_ADDR    = {r_grant, r_ptr[r_grant]};
  assign out_DATA    = r_data;
  assign out_WE      = r_we;
  assign busy        = (r_state != IDLE);
  assign grant_ch    = r_grant;
  assign err_timeout = r_err;

endmodule
